// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: funct3 op codes, FSM states
// and op-decode helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} mdu_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // rs2 selects which operand's signedness is asked for (0: rs1, 1: rs2).
  function automatic logic is_signed(input logic [2:0] op, input logic rs2);
    if (op[2]) return ~op[0];
    return rs2 ? ~op[1] : (op != MDU_MULHU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-divide step: shift in one dividend bit, try to
// subtract the divisor, keep the difference when it does not go negative.
module mdu_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dividend_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff;

  always_comb begin
    trial   = {rem_i, dividend_bit_i};
    q_bit_o = (trial >= {1'b0, divisor_i});
    // Only meaningful when q_bit_o is set, in which case it fits in XLEN bits.
    diff    = trial[XLEN-1:0] - divisor_i;
    rem_o   = q_bit_o ? diff : trial[XLEN-1:0];
  end

endmodule

// File: rtl/riscv_mdu.sv
// Multi-cycle RV M-extension multiply/divide unit with valid/ready on both sides.
// Define MDU_FAST_MUL_EN to use a single-cycle multiplier for the MUL* ops.
module riscv_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int unsigned K  = XLEN / STEP_BITS;
  localparam int unsigned CW = $clog2(K) + 1;
  localparam logic [CW-1:0]   CntMax = CW'(K - 1);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] acc_q, sh_q, b_q;
  logic [XLEN-1:0] out_result_q;
  logic            out_valid_q;

  // Accept-side decode
  logic            sa_en, sb_en, a_neg, b_neg, in_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    sa_en    = is_signed(in_op, 1'b0);
    sb_en    = is_signed(in_op, 1'b1);
    a_neg    = sa_en & in_a[XLEN-1];
    b_neg    = sb_en & in_b[XLEN-1];
    a_mag    = a_neg ? -in_a : in_a;
    b_mag    = b_neg ? -in_b : in_b;
    in_neg   = is_rem(in_op) ? a_neg : (a_neg ^ b_neg);
    div_zero = (in_b == '0);
    div_ovf  = sa_en && (in_a == MinInt) && (in_b == '1);
    special  = is_div(in_op) && (div_zero || div_ovf);
    if (div_zero) special_res = is_rem(in_op) ? in_a : '1;
    else          special_res = is_rem(in_op) ? '0 : in_a;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fprod;

  // Sign-extension to 2*XLEN is enough: only the low 2*XLEN product bits are used.
  always_comb begin
    fa       = {{XLEN{a_neg}}, in_a};
    fb       = {{XLEN{b_neg}}, in_b};
    fprod    = fa * fb;
    fast_hit = !is_div(in_op);
    fast_res = (in_op == MDU_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
  end
`else
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
  end
`endif

  // Divide step chain: acc holds the partial remainder, sh shifts dividend out / quotient in.
  logic [XLEN-1:0] drem [STEP_BITS+1];
  logic [XLEN-1:0] dsh  [STEP_BITS+1];
  logic [STEP_BITS-1:0] qb;

  assign drem[0] = acc_q;
  assign dsh[0]  = sh_q;

  for (genvar i = 0; i < STEP_BITS; i++) begin : g_div_step
    mdu_div_step #(.XLEN(XLEN)) u_step (
      .rem_i          (drem[i]),
      .dividend_bit_i (dsh[i][XLEN-1]),
      .divisor_i      (b_q),
      .rem_o          (drem[i+1]),
      .q_bit_o        (qb[i])
    );
    assign dsh[i+1] = {dsh[i][XLEN-2:0], qb[i]};
  end

  // Shift-add multiply on the same registers: acc is the high half, sh the multiplier/low half.
  logic [XLEN-1:0] mhi, msh;
  logic [XLEN:0]   msum;

  always_comb begin
    mhi  = acc_q;
    msh  = sh_q;
    msum = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      msum = {1'b0, mhi} + (msh[0] ? {1'b0, b_q} : '0);
      mhi  = msum[XLEN:1];
      msh  = {msum[0], msh[XLEN-1:1]};
    end
  end

  // Sign fix-up of the magnitude result
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_res, fix_res;

  always_comb begin
    prod_fix = neg_q ? -{acc_q, sh_q} : {acc_q, sh_q};
    div_res  = is_rem(op_q) ? acc_q : sh_q;
    if (is_div(op_q))           fix_res = neg_q ? -div_res : div_res;
    else if (op_q == MDU_MUL)   fix_res = prod_fix[XLEN-1:0];
    else                        fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_q         <= MDU_MUL;
      neg_q        <= 1'b0;
      acc_q        <= '0;
      sh_q         <= '0;
      b_q          <= '0;
      out_result_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q  <= in_op;
            neg_q <= in_neg;
            cnt_q <= '0;
            acc_q <= '0;
            sh_q  <= a_mag;
            b_q   <= b_mag;
            if (special) begin
              out_result_q <= special_res;
              state_q      <= StDone;
            end else if (fast_hit) begin
              out_result_q <= fast_res;
              state_q      <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= is_div(op_q) ? drem[STEP_BITS] : mhi;
          sh_q  <= is_div(op_q) ? dsh[STEP_BITS] : msh;
          if (cnt_q == CntMax) state_q <= StFix;
          else                 cnt_q   <= cnt_q + 1'b1;
        end
        StFix: begin
          out_result_q <= fix_res;
          out_valid_q  <= 1'b1;
          state_q      <= StDone;
        end
        StDone: begin
          // Short-cut results enter here with out_valid low; raise it one edge later.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule
